// File: rtl/prime_seq_counter.sv
// Prime-sequence counter: steps through 0 followed by every prime below 2**WIDTH.
// Supports up/down stepping, indexed load, a wrap pulse and a load-error pulse.
module prime_seq_counter #(
  parameter  int WIDTH = 3,
  localparam int N  = (WIDTH == 2) ? 3  : (WIDTH == 3) ? 5  : (WIDTH == 4) ? 7  :
                      (WIDTH == 5) ? 12 : (WIDTH == 6) ? 19 : (WIDTH == 7) ? 32 :
                      (WIDTH == 8) ? 55 : 3,
  localparam int IW = (N > 2) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [IW-1:0]    load_idx,
  output logic [WIDTH-1:0] count,
  output logic [IW-1:0]    idx,
  output logic             wrap,
  output logic             load_err
);

  function automatic bit is_prime(int v);
    if (v < 2) return 1'b0;
    for (int d = 2; d * d <= v; d++)
      if (v % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int count_primes();
    int c;
    c = 0;
    for (int v = 2; v < (1 << WIDTH); v++)
      if (is_prime(v)) c++;
    return c;
  endfunction

  function automatic logic [N-1:0][WIDTH-1:0] build_seq();
    logic [N-1:0][WIDTH-1:0] s;
    int k;
    s = '0;
    k = 1;
    for (int v = 2; v < (1 << WIDTH); v++) begin
      if (is_prime(v)) begin
        if (k < N) s[k] = WIDTH'(v);
        k++;
      end
    end
    return s;
  endfunction

  localparam logic [N-1:0][WIDTH-1:0] SEQ = build_seq();
  localparam logic [IW:0]   N_EXT = (IW + 1)'(N);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);

  // The closed-form N table must agree with the sieve that fills the ROM.
  if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
    $error("prime_seq_counter: WIDTH must be in 2..8");
  end else if (count_primes() + 1 != N) begin : g_bad_n
    $error("prime_seq_counter: sequence length table inconsistent");
  end

  logic [WIDTH-1:0] r_count;
  logic [IW-1:0]    r_idx;
  logic             r_wrap;
  logic             r_load_err;

  logic [IW-1:0]    w_nidx;
  logic             w_wrap;
  logic             w_err;
  logic             w_ld_ok;

  assign w_ld_ok = ({1'b0, load_idx} < N_EXT);

  always_comb begin
    w_nidx = r_idx;
    w_wrap = 1'b0;
    w_err  = 1'b0;
    if (load) begin
      if (w_ld_ok) w_nidx = load_idx;
      else         w_err  = 1'b1;
    end else if (en) begin
      if (dir) begin
        if (r_idx == LAST) begin
          w_nidx = '0;
          w_wrap = 1'b1;
        end else begin
          w_nidx = r_idx + 1'b1;
        end
      end else begin
        if (r_idx == '0) begin
          w_nidx = LAST;
          w_wrap = 1'b1;
        end else begin
          w_nidx = r_idx - 1'b1;
        end
      end
    end
  end

  // Count is looked up from the next index so count == seq[idx] holds every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx      <= '0;
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_idx      <= w_nidx;
      r_count    <= SEQ[w_nidx];
      r_wrap     <= w_wrap;
      r_load_err <= w_err;
    end
  end

  assign count    = r_count;
  assign idx      = r_idx;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_prime_seq_counter.sv
// Bench for prime_seq_counter: four instances (WIDTH 3,4,5,8) checked against a
// sieve-based reference through an expected-value queue.
module tb_prime_seq_counter;

  typedef struct {
    int c;
    int i;
    int w;
    int e;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic en3, dir3, ld3; logic [2:0] li3; logic [2:0] cnt3; logic [2:0] idx3; logic wr3, er3;
  logic en4, dir4, ld4; logic [2:0] li4; logic [3:0] cnt4; logic [2:0] idx4; logic wr4, er4;
  logic en5, dir5, ld5; logic [3:0] li5; logic [4:0] cnt5; logic [3:0] idx5; logic wr5, er5;
  logic en8, dir8, ld8; logic [5:0] li8; logic [7:0] cnt8; logic [5:0] idx8; logic wr8, er8;

  prime_seq_counter #(.WIDTH(3)) u_w3 (.clk(clk), .reset(reset), .en(en3), .dir(dir3),
    .load(ld3), .load_idx(li3), .count(cnt3), .idx(idx3), .wrap(wr3), .load_err(er3));
  prime_seq_counter #(.WIDTH(4)) u_w4 (.clk(clk), .reset(reset), .en(en4), .dir(dir4),
    .load(ld4), .load_idx(li4), .count(cnt4), .idx(idx4), .wrap(wr4), .load_err(er4));
  prime_seq_counter #(.WIDTH(5)) u_w5 (.clk(clk), .reset(reset), .en(en5), .dir(dir5),
    .load(ld5), .load_idx(li5), .count(cnt5), .idx(idx5), .wrap(wr5), .load_err(er5));
  prime_seq_counter #(.WIDTH(8)) u_w8 (.clk(clk), .reset(reset), .en(en8), .dir(dir8),
    .load(ld8), .load_idx(li8), .count(cnt8), .idx(idx8), .wrap(wr8), .load_err(er8));

  int   cmp_cnt = 0;
  int   mis_cnt = 0;
  int   pl[$];
  int   nn[4];
  int   m_idx[4];
  exp_t sbq[$];
  exp_t e, g;

  function automatic int seq_val(int k);
    return (k == 0) ? 0 : pl[k-1];
  endfunction

  function automatic int width_of(int d);
    return (d == 0) ? 3 : (d == 1) ? 4 : (d == 2) ? 5 : 8;
  endfunction

  task automatic build_sieve();
    bit comp[256];
    for (int v = 0; v < 256; v++) comp[v] = 1'b0;
    for (int v = 2; v < 256; v++) begin
      if (!comp[v]) begin
        pl.push_back(v);
        for (int m = v * 2; m < 256; m += v) comp[m] = 1'b1;
      end
    end
    for (int d = 0; d < 4; d++) begin
      nn[d] = 1;
      foreach (pl[k]) if (pl[k] < (1 << width_of(d))) nn[d]++;
    end
  endtask

  function automatic exp_t model_step(int d, bit en, bit dir, bit ld, int li);
    exp_t r;
    r.w = 0;
    r.e = 0;
    if (ld) begin
      if (li < nn[d]) m_idx[d] = li;
      else            r.e = 1;
    end else if (en) begin
      if (dir) begin
        if (m_idx[d] == nn[d] - 1) begin m_idx[d] = 0; r.w = 1; end
        else m_idx[d]++;
      end else begin
        if (m_idx[d] == 0) begin m_idx[d] = nn[d] - 1; r.w = 1; end
        else m_idx[d]--;
      end
    end
    r.i = m_idx[d];
    r.c = seq_val(r.i);
    return r;
  endfunction

  function automatic exp_t obs(int d);
    exp_t r;
    case (d)
      0: r = '{c: int'(cnt3), i: int'(idx3), w: int'(wr3), e: int'(er3)};
      1: r = '{c: int'(cnt4), i: int'(idx4), w: int'(wr4), e: int'(er4)};
      2: r = '{c: int'(cnt5), i: int'(idx5), w: int'(wr5), e: int'(er5)};
      default: r = '{c: int'(cnt8), i: int'(idx8), w: int'(wr8), e: int'(er8)};
    endcase
    return r;
  endfunction

  task automatic drive(int d, bit en, bit dir, bit ld, int li);
    {en3, dir3, ld3, li3} = '0;
    {en4, dir4, ld4, li4} = '0;
    {en5, dir5, ld5, li5} = '0;
    {en8, dir8, ld8, li8} = '0;
    case (d)
      0: begin en3 = en; dir3 = dir; ld3 = ld; li3 = 3'(li); end
      1: begin en4 = en; dir4 = dir; ld4 = ld; li4 = 3'(li); end
      2: begin en5 = en; dir5 = dir; ld5 = ld; li5 = 4'(li); end
      default: begin en8 = en; dir8 = dir; ld8 = ld; li8 = 6'(li); end
    endcase
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int d = 0; d < 4; d++) m_idx[d] = 0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      g = obs(d);
      cmp_cnt++;
      if (g.c !== 0 || g.i !== 0 || g.w !== 0 || g.e !== 0) begin
        mis_cnt++;
        $display("FAIL reset_w%0d: got count=%0d idx=%0d wrap=%0d err=%0d, want all 0",
                 width_of(d), g.c, g.i, g.w, g.e);
      end
    end
    reset = 1'b1;
    for (int d = 0; d < 4; d++) m_idx[d] = 0;
  endtask

  task automatic test_legacy_up();
    int leg[5] = '{2, 3, 5, 7, 0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 1, 0, 0);
      sbq.push_back(model_step(0, 1, 1, 0, 0));
      @(posedge clk); #1;
      e = sbq.pop_front();
      g = obs(0);
      cmp_cnt++;
      if (g.c !== e.c || g.i !== e.i || g.w !== e.w || g.e !== e.e) begin
        mis_cnt++;
        $display("FAIL legacy_up step%0d: got c=%0d i=%0d w=%0d e=%0d, want c=%0d i=%0d w=%0d e=%0d",
                 k, g.c, g.i, g.w, g.e, e.c, e.i, e.w, e.e);
      end
      cmp_cnt++;
      if (g.c !== leg[k] || g.w !== int'(k == 4)) begin
        mis_cnt++;
        $display("FAIL legacy_seq step%0d: got c=%0d w=%0d, want c=%0d w=%0d",
                 k, g.c, g.w, leg[k], int'(k == 4));
      end
    end
  endtask

  task automatic test_down_w5();
    int want[4] = '{31, 29, 23, 19};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(2, 1, 0, 0, 0);
      sbq.push_back(model_step(2, 1, 0, 0, 0));
      @(posedge clk); #1;
      e = sbq.pop_front();
      g = obs(2);
      cmp_cnt++;
      if (g.c !== e.c || g.i !== e.i || g.w !== e.w || g.e !== e.e) begin
        mis_cnt++;
        $display("FAIL down_w5 step%0d: got c=%0d i=%0d w=%0d e=%0d, want c=%0d i=%0d w=%0d e=%0d",
                 k, g.c, g.i, g.w, g.e, e.c, e.i, e.w, e.e);
      end
      cmp_cnt++;
      if (g.c !== want[k] || g.w !== int'(k == 0) || (k == 0 && g.i !== 11)) begin
        mis_cnt++;
        $display("FAIL down_w5_const step%0d: got c=%0d i=%0d w=%0d, want c=%0d w=%0d",
                 k, g.c, g.i, g.w, want[k], int'(k == 0));
      end
    end
  endtask

  task automatic test_load_w4();
    int ld_t[3] = '{1, 1, 0};
    int li_t[3] = '{4, 7, 0};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1'(k == 0), 1, 1'(ld_t[k]), li_t[k]);
      sbq.push_back(model_step(1, 1'(k == 0), 1, 1'(ld_t[k]), li_t[k]));
      @(posedge clk); #1;
      e = sbq.pop_front();
      g = obs(1);
      cmp_cnt++;
      if (g.c !== e.c || g.i !== e.i || g.w !== e.w || g.e !== e.e) begin
        mis_cnt++;
        $display("FAIL load_w4 step%0d: got c=%0d i=%0d w=%0d e=%0d, want c=%0d i=%0d w=%0d e=%0d",
                 k, g.c, g.i, g.w, g.e, e.c, e.i, e.w, e.e);
      end
      cmp_cnt++;
      if (g.c !== 7 || g.e !== int'(k == 1)) begin
        mis_cnt++;
        $display("FAIL load_w4_const step%0d: got c=%0d e=%0d, want c=7 e=%0d",
                 k, g.c, g.e, int'(k == 1));
      end
    end
  endtask

  task automatic test_full_w8();
    do_reset();
    for (int k = 1; k <= 55; k++) begin
      drive(3, 1, 1, 0, 0);
      sbq.push_back(model_step(3, 1, 1, 0, 0));
      @(posedge clk); #1;
      e = sbq.pop_front();
      g = obs(3);
      cmp_cnt++;
      if (g.c !== e.c || g.i !== e.i || g.w !== e.w || g.e !== e.e) begin
        mis_cnt++;
        $display("FAIL full_w8 step%0d: got c=%0d i=%0d w=%0d e=%0d, want c=%0d i=%0d w=%0d e=%0d",
                 k, g.c, g.i, g.w, g.e, e.c, e.i, e.w, e.e);
      end
      if (k == 54) begin
        cmp_cnt++;
        if (g.c !== 251 || g.i !== 54) begin
          mis_cnt++;
          $display("FAIL full_w8_top: got c=%0d i=%0d, want c=251 i=54", g.c, g.i);
        end
      end
    end
  endtask

  task automatic test_dir_toggle_w5();
    bit en_t[6]  = '{0, 1, 1, 1, 1, 0};
    bit dir_t[6] = '{0, 1, 0, 1, 0, 1};
    int want[6]  = '{13, 17, 13, 17, 13, 13};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(2, en_t[k], dir_t[k], 1'(k == 0), 6);
      sbq.push_back(model_step(2, en_t[k], dir_t[k], 1'(k == 0), 6));
      @(posedge clk); #1;
      e = sbq.pop_front();
      g = obs(2);
      cmp_cnt++;
      if (g.c !== e.c || g.i !== e.i || g.w !== e.w || g.e !== e.e || g.c !== want[k]) begin
        mis_cnt++;
        $display("FAIL dir_toggle step%0d: got c=%0d i=%0d w=%0d e=%0d, want c=%0d i=%0d w=%0d e=%0d",
                 k, g.c, g.i, g.w, g.e, want[k], e.i, e.w, e.e);
      end
    end
  endtask

  task automatic test_async_reset_w4();
    do_reset();
    drive(1, 0, 1, 1, 5);
    sbq.push_back(model_step(1, 0, 1, 1, 5));
    @(posedge clk); #1;
    e = sbq.pop_front();
    g = obs(1);
    cmp_cnt++;
    if (g.c !== e.c || g.i !== e.i || g.c !== 11) begin
      mis_cnt++;
      $display("FAIL arst_preload: got c=%0d i=%0d, want c=11 i=%0d", g.c, g.i, e.i);
    end
    drive(1, 1, 1, 0, 0);
    #3 reset = 1'b0;
    #1;
    g = obs(1);
    cmp_cnt++;
    if (g.c !== 0 || g.i !== 0 || g.w !== 0) begin
      mis_cnt++;
      $display("FAIL arst_immediate: got c=%0d i=%0d w=%0d, want 0 0 0", g.c, g.i, g.w);
    end
    for (int d = 0; d < 4; d++) m_idx[d] = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      g = obs(1);
      cmp_cnt++;
      if (g.c !== 0 || g.i !== 0 || g.w !== 0) begin
        mis_cnt++;
        $display("FAIL arst_hold cyc%0d: got c=%0d i=%0d w=%0d, want 0 0 0", k, g.c, g.i, g.w);
      end
    end
    reset = 1'b1;
    sbq.push_back(model_step(1, 1, 1, 0, 0));
    @(posedge clk); #1;
    e = sbq.pop_front();
    g = obs(1);
    cmp_cnt++;
    if (g.c !== e.c || g.i !== e.i || g.w !== e.w || g.e !== e.e || g.c !== 2) begin
      mis_cnt++;
      $display("FAIL arst_release: got c=%0d i=%0d w=%0d e=%0d, want c=2 i=%0d w=%0d e=%0d",
               g.c, g.i, g.w, g.e, e.i, e.w, e.e);
    end
  endtask

  task automatic test_random();
    int d, li;
    bit en, dir, ld;
    do_reset();
    for (int k = 0; k < 120; k++) begin
      d   = (k < 60) ? 2 : 0;
      en  = 1'($urandom_range(0, 3) != 0);
      dir = 1'($urandom_range(0, 1));
      ld  = 1'($urandom_range(0, 5) == 0);
      li  = (d == 2) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 7));
      drive(d, en, dir, ld, li);
      sbq.push_back(model_step(d, en, dir, ld, li));
      @(posedge clk); #1;
      e = sbq.pop_front();
      g = obs(d);
      cmp_cnt++;
      if (g.c !== e.c || g.i !== e.i || g.w !== e.w || g.e !== e.e) begin
        mis_cnt++;
        $display("FAIL random_w%0d step%0d: got c=%0d i=%0d w=%0d e=%0d, want c=%0d i=%0d w=%0d e=%0d",
                 width_of(d), k, g.c, g.i, g.w, g.e, e.c, e.i, e.w, e.e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 0);
    build_sieve();
    test_reset();
    test_legacy_up();
    test_down_w5();
    test_load_w4();
    test_full_w8();
    test_dir_toggle_w5();
    test_async_reset_w4();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
